// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-core arbiter for a single-port data RAM (IDLE/ISSUE/WAIT/DONE).
//               Optional macro ARB_ROUND_ROBIN_EN selects round-robin grants.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                pick;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_grant_q, last_grant_d;

  // On a tie the core that did not win last time is chosen.
  always_comb begin
    if (c0_req && c1_req) pick = ~last_grant_q;
    else                  pick = c1_req;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
`else
  assign pick = ~c0_req;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (c0_req || c1_req) begin
          grant_d = pick;
          we_d    = pick ? c1_we    : c0_we;
          addr_d  = pick ? c1_addr  : c0_addr;
          wdata_d = pick ? c1_wdata : c0_wdata;
          state_d = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = pick;
`endif
        end
      end
      ISSUE: state_d = we_q ? DONE : WAIT;
      WAIT: begin
        if (grant_q) rdata1_d = mem_rdata;
        else         rdata0_d = mem_rdata;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode from the state register only, so reset clears them at once.
  assign mem_rd    = (state_q == ISSUE) && !we_q;
  assign mem_wr    = (state_q == ISSUE) &&  we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign c0_ack    = (state_q == DONE) && !grant_q;
  assign c1_ack    = (state_q == DONE) &&  grant_q;
  assign c0_rdata  = rdata0_q;
  assign c1_rdata  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        c0_req = 1'b0, c0_we = 1'b0;
  logic [15:0] c0_addr = '0, c0_wdata = '0;
  logic        c0_ack;
  logic [15:0] c0_rdata;
  logic        c1_req = 1'b0, c1_we = 1'b0;
  logic [15:0] c1_addr = '0, c1_wdata = '0;
  logic        c1_ack;
  logic [15:0] c1_rdata;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_wr, mem_rd;
  logic [15:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rdata(c1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears in the cycle after the RD cycle.
  bit [15:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic prev0 = 1'b0, prev1 = 1'b0;
  always @(negedge clk) begin
    if (rstn) begin
      chk("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
      chk("c0_ack_double", {31'd0, c0_ack & prev0}, 32'd0);
      chk("c1_ack_double", {31'd0, c1_ack & prev1}, 32'd0);
    end
    prev0 = c0_ack;
    prev1 = c1_ack;
  end

  // One complete transaction from a single core; checks latency and strobes.
  task automatic txn(input bit core, input bit we, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_rd);
    int lat;
    lat = we ? 2 : 3;
    if (core) begin c1_we = we; c1_addr = addr; c1_wdata = wdata; c1_req = 1'b1; end
    else      begin c0_we = we; c0_addr = addr; c0_wdata = wdata; c0_req = 1'b1; end
    for (int i = 1; i <= lat; i++) begin
      step();
      chk(core ? "c1_ack" : "c0_ack", core ? c1_ack : c0_ack, (i == lat));
      chk(core ? "c0_ack_idle" : "c1_ack_idle", core ? c0_ack : c1_ack, 0);
      if (i == 1) begin
        chk("issue_rd", mem_rd, !we);
        chk("issue_wr", mem_wr, we);
        chk("issue_addr", mem_addr, addr);
        if (we) chk("issue_wdata", mem_wdata, wdata);
      end else begin
        chk("post_issue_strobes", {mem_rd, mem_wr}, 0);
      end
    end
    if (!we) chk(core ? "c1_rdata" : "c0_rdata", core ? c1_rdata : c0_rdata, exp_rd);
    step();
    if (core) c1_req = 1'b0; else c0_req = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {c0_ack, c1_ack}, 0);
    chk("rst_c0_rdata", c0_rdata, 0);
    chk("rst_c1_rdata", c1_rdata, 0);
    rstn = 1'b1;
    step();

    // c0 write/read at address 0
    txn(1'b0, 1'b1, 16'h0000, 16'h00FF, 16'h0000);
    txn(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00FF);

    // c1 write/read at top address; c0 must remain idle and keep its data
    txn(1'b1, 1'b1, 16'hFFFF, 16'hFF00, 16'h0000);
    txn(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFF00);
    chk("c0_rdata_hold", c0_rdata, 16'h00FF);

    // Simultaneous reads, four rounds: c0 first, then c1
    for (int r = 0; r < 4; r++) begin
      c0_we = 1'b0; c0_addr = 16'h0000; c0_req = 1'b1;
      c1_we = 1'b0; c1_addr = 16'hFFFF; c1_req = 1'b1;
      for (int i = 1; i <= 3; i++) begin
        step();
        chk("tie_c0_ack", c0_ack, (i == 3));
        chk("tie_c1_wait", c1_ack, 0);
        if (i == 1) chk("tie_c0_addr", mem_addr, 16'h0000);
      end
      chk("tie_c0_rdata", c0_rdata, 16'h00FF);
      step();
      c0_req = 1'b0;
      for (int i = 1; i <= 3; i++) begin
        step();
        chk("tie_c1_ack", c1_ack, (i == 3));
        chk("tie_c0_quiet", c0_ack, 0);
        if (i == 1) chk("tie_c1_addr", mem_addr, 16'hFFFF);
      end
      chk("tie_c1_rdata", c1_rdata, 16'hFF00);
      step();
      c1_req = 1'b0;
    end

    // c1 arrives while c0's read is in WAIT
    c0_we = 1'b0; c0_addr = 16'h0000; c0_req = 1'b1;
    step();
    step();
    c1_we = 1'b0; c1_addr = 16'hFFFF; c1_req = 1'b1;
    step();
    chk("late_c0_ack", c0_ack, 1);
    chk("late_c1_ack", c1_ack, 0);
    chk("late_c0_addr_kept", mem_addr, 16'h0000);
    chk("late_c0_rdata", c0_rdata, 16'h00FF);
    step();
    c0_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("late_c1_ack_seq", c1_ack, (i == 3));
      if (i == 1) chk("late_c1_addr", mem_addr, 16'hFFFF);
    end
    chk("late_c1_rdata", c1_rdata, 16'hFF00);
    step();
    c1_req = 1'b0;

    // Reset during ISSUE of a write to address 1
    c0_we = 1'b1; c0_addr = 16'h0001; c0_wdata = 16'h1234; c0_req = 1'b1;
    step();
    chk("pre_rst_mem_wr", mem_wr, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_mem_wr", mem_wr, 0);
    chk("arst_mem_rd", mem_rd, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_acks", {c0_ack, c1_ack}, 0);
    chk("arst_rdata", {c0_rdata, c1_rdata}, 0);
    c0_req = 1'b0;
    #2 rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_ack", {c0_ack, c1_ack}, 0);
      chk("post_rst_no_strobe", {mem_rd, mem_wr}, 0);
    end

    // Abandoned write never reached the RAM; earlier data survives
    txn(1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0000);
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h00FF);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
